nubus_arb_sequencer: RTL and testbench

NUBUS_ARB_SEQUENCER -- requirements
Module: nubus_arb_sequencer

---
 rtl/nubus_arb_sequencer_if.sv | 43 ++++
 rtl/nubus_arb_sequencer.sv | 119 +++++++++++
 tb/tb_nubus_arb_sequencer.sv | 366 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/nubus_arb_sequencer_if.sv
// NuBus arbitration sequencer signal bundle.
// Local master handshake plus observed/driven bus lines.
interface nubus_arb_sequencer_if;
  logic mst_req;
  logic mst_lock;
  logic mst_done;
  logic bus_start_i;
  logic bus_ack_i;
  logic bus_rqst_i;
  logic grant;
  logic rqst_o;
  logic arbena;
  logic mst_gnt;
  logic mst_owner;

  modport slave (
    input  mst_req,
    input  mst_lock,
    input  mst_done,
    input  bus_start_i,
    input  bus_ack_i,
    input  bus_rqst_i,
    input  grant,
    output rqst_o,
    output arbena,
    output mst_gnt,
    output mst_owner
  );

  modport master (
    output mst_req,
    output mst_lock,
    output mst_done,
    output bus_start_i,
    output bus_ack_i,
    output bus_rqst_i,
    output grant,
    input  rqst_o,
    input  arbena,
    input  mst_gnt,
    input  mst_owner
  );
endinterface

// File: rtl/nubus_arb_sequencer.sv
// NuBus arbitration sequencer: contest, lockout and tenure.
// All outputs come straight from flops.
module nubus_arb_sequencer #(
  parameter int ARB_CYCLES = 2,
  parameter int FAIR       = 1
) (
  input logic                  nub_clk,
  input logic                  nub_reset,
  nubus_arb_sequencer_if.slave nb
);
  typedef enum logic [2:0] {
    IDLE,
    ARB,
    LOST,
    WAIT_BUS,
    OWN
  } state_t;

  localparam logic [3:0] CNT_LOAD = 4'(ARB_CYCLES - 1);

  state_t     r_state;
  state_t     w_nxt;
  logic [3:0] r_cnt;
  logic [3:0] w_cnt_nxt;
  logic       r_busy;
  logic       r_fair;
  logic       r_rqst;
  logic       r_arbena;
  logic       r_gnt;
  logic       r_owner;
  logic       w_exit_own;

  assign w_exit_own = (r_state == OWN) && (w_nxt == IDLE);

  // next-state and settle-counter decode
  always_comb begin
    w_nxt     = r_state;
    w_cnt_nxt = r_cnt;
    unique case (r_state)
      IDLE: begin
        if (nb.mst_req && !r_fair) begin
          w_nxt     = ARB;
          w_cnt_nxt = CNT_LOAD;
        end
      end
      ARB: begin
        if (!nb.mst_req) begin
          w_nxt = IDLE;
        end else if (r_cnt == 4'd0) begin
          w_nxt = nb.grant ? WAIT_BUS : LOST;
        end else begin
          w_cnt_nxt = r_cnt - 4'd1;
        end
      end
      LOST: begin
        if (!nb.mst_req) begin
          w_nxt = IDLE;
        end else if (nb.bus_start_i) begin
          w_nxt     = ARB;
          w_cnt_nxt = CNT_LOAD;
        end
      end
      WAIT_BUS: begin
        if ((!r_busy && !nb.bus_start_i) || nb.bus_ack_i)
          w_nxt = OWN;
      end
      OWN: begin
        if (nb.mst_done && !(nb.mst_lock && nb.mst_req))
          w_nxt = IDLE;
      end
      default: w_nxt = IDLE;
    endcase
  end

  // state, counter and registered outputs
  always_ff @(posedge nub_clk) begin
    if (nub_reset) begin
      r_state  <= IDLE;
      r_cnt    <= 4'd0;
      r_rqst   <= 1'b0;
      r_arbena <= 1'b0;
      r_gnt    <= 1'b0;
      r_owner  <= 1'b0;
    end else begin
      r_state  <= w_nxt;
      r_cnt    <= w_cnt_nxt;
      r_rqst   <= (w_nxt == ARB) || (w_nxt == LOST)
               || (w_nxt == WAIT_BUS);
      r_arbena <= (w_nxt == ARB) || (w_nxt == WAIT_BUS);
      r_gnt    <= (w_nxt == OWN) && (r_state != OWN);
      r_owner  <= (w_nxt == OWN);
    end
  end

  // bus activity tracker; a new START wins over a same-cycle ACK
  always_ff @(posedge nub_clk) begin
    if (nub_reset)
      r_busy <= 1'b0;
    else if (nb.bus_start_i)
      r_busy <= 1'b1;
    else if (nb.bus_ack_i)
      r_busy <= 1'b0;
  end

  // fairness lockout: set on tenure exit, released once /RQST is quiet
  always_ff @(posedge nub_clk) begin
    if (nub_reset || FAIR == 0)
      r_fair <= 1'b0;
    else if (w_exit_own)
      r_fair <= 1'b1;
    else if (!nb.bus_rqst_i)
      r_fair <= 1'b0;
  end

  assign nb.rqst_o    = r_rqst;
  assign nb.arbena    = r_arbena;
  assign nb.mst_gnt   = r_gnt;
  assign nb.mst_owner = r_owner;
endmodule

// File: tb/tb_nubus_arb_sequencer.sv
// Bench for nubus_arb_sequencer: directed tables plus random
// stimulus against a tenure-level reference model.
module tb_nubus_arb_sequencer;
  localparam int AC = 2;

  localparam logic [7:0] R = 8'h80;
  localparam logic [7:0] Q = 8'h40;
  localparam logic [7:0] L = 8'h20;
  localparam logic [7:0] D = 8'h10;
  localparam logic [7:0] S = 8'h08;
  localparam logic [7:0] A = 8'h04;
  localparam logic [7:0] B = 8'h02;
  localparam logic [7:0] G = 8'h01;

  localparam logic [3:0] IDL = 4'b0000;
  localparam logic [3:0] ARB = 4'b1100;
  localparam logic [3:0] WT  = 4'b1100;
  localparam logic [3:0] LST = 4'b1000;
  localparam logic [3:0] GNT = 4'b0011;
  localparam logic [3:0] OWN = 4'b0001;

  localparam int P_IDLE = 0;
  localparam int P_CONT = 1;
  localparam int P_LOST = 2;
  localparam int P_WON  = 3;
  localparam int P_TEN  = 4;

  typedef struct packed {
    logic [7:0] s;
    logic [3:0] e0;
    logic [3:0] e1;
  } step_t;

  logic clk   = 1'b0;
  logic rst   = 1'b1;
  logic req   = 1'b0;
  logic lock  = 1'b0;
  logic done  = 1'b0;
  logic start = 1'b0;
  logic ack   = 1'b0;
  logic rqi   = 1'b0;
  logic gnt   = 1'b0;
  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  nubus_arb_sequencer_if if0 ();
  nubus_arb_sequencer_if if1 ();

  assign if0.mst_req     = req;
  assign if0.mst_lock    = lock;
  assign if0.mst_done    = done;
  assign if0.bus_start_i = start;
  assign if0.bus_ack_i   = ack;
  assign if0.bus_rqst_i  = rqi;
  assign if0.grant       = gnt;
  assign if1.mst_req     = req;
  assign if1.mst_lock    = lock;
  assign if1.mst_done    = done;
  assign if1.bus_start_i = start;
  assign if1.bus_ack_i   = ack;
  assign if1.bus_rqst_i  = rqi;
  assign if1.grant       = gnt;

  nubus_arb_sequencer #(.ARB_CYCLES(AC), .FAIR(1)) u0 (
    .nub_clk  (clk),
    .nub_reset(rst),
    .nb       (if0)
  );

  nubus_arb_sequencer #(.ARB_CYCLES(AC), .FAIR(0)) u1 (
    .nub_clk  (clk),
    .nub_reset(rst),
    .nb       (if1)
  );

  logic [3:0] o0;
  logic [3:0] o1;
  assign o0 = {if0.rqst_o, if0.arbena, if0.mst_gnt, if0.mst_owner};
  assign o1 = {if1.rqst_o, if1.arbena, if1.mst_gnt, if1.mst_owner};

  // reference model, index 0 = fairness on, index 1 = off
  int ph[2]    = '{0, 0};
  int spent[2] = '{0, 0};
  bit busy[2]  = '{0, 0};
  bit blk[2]   = '{0, 0};
  bit newg[2]  = '{0, 0};

  function automatic logic [3:0] mexp(int k);
    return {ph[k] == P_CONT || ph[k] == P_LOST || ph[k] == P_WON,
            ph[k] == P_CONT || ph[k] == P_WON,
            newg[k],
            ph[k] == P_TEN};
  endfunction

  task automatic model_step(int k);
    int np;
    bit ex;
    np = ph[k];
    ex = 1'b0;
    newg[k] = 1'b0;
    if (rst) begin
      ph[k] = P_IDLE;
      spent[k] = 0;
      busy[k] = 1'b0;
      blk[k] = 1'b0;
      return;
    end
    case (ph[k])
      P_IDLE:
        if (req && !blk[k]) begin
          np = P_CONT;
          spent[k] = 0;
        end
      P_CONT:
        if (!req) np = P_IDLE;
        else if (spent[k] + 1 >= AC) np = gnt ? P_WON : P_LOST;
        else spent[k] = spent[k] + 1;
      P_LOST:
        if (!req) np = P_IDLE;
        else if (start) begin
          np = P_CONT;
          spent[k] = 0;
        end
      P_WON:
        if ((!busy[k] && !start) || ack) begin
          np = P_TEN;
          newg[k] = 1'b1;
        end
      P_TEN:
        if (done && !(lock && req)) begin
          np = P_IDLE;
          ex = 1'b1;
        end
      default: np = P_IDLE;
    endcase
    if (k == 1) blk[k] = 1'b0;
    else if (ex) blk[k] = 1'b1;
    else if (!rqi) blk[k] = 1'b0;
    busy[k] = start ? 1'b1 : (ack ? 1'b0 : busy[k]);
    ph[k] = np;
  endtask

  task automatic apply(logic [7:0] s);
    {rst, req, lock, done, start, ack, rqi, gnt} = s;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step(0);
    model_step(1);
    #1;
  endtask

  task automatic test_reset();
    step_t t[3] = '{
      '{R | Q | S | G, IDL, IDL},
      '{R | Q | D | A, IDL, IDL},
      '{8'h00,         IDL, IDL}
    };
    foreach (t[i]) begin
      apply(t[i].s);
      tick();
      total++;
      if (o0 !== t[i].e0 || o1 !== t[i].e1) begin
        bad++;
        $display("FAIL reset step %0d: got %b/%b want %b/%b",
                 i, o0, o1, t[i].e0, t[i].e1);
      end
    end
  endtask

  task automatic test_basic();
    step_t t[7] = '{
      '{Q | G, ARB, ARB},
      '{Q | G, ARB, ARB},
      '{Q | G, WT,  WT },
      '{Q | G, GNT, GNT},
      '{Q | G, OWN, OWN},
      '{D,     IDL, IDL},
      '{8'h00, IDL, IDL}
    };
    foreach (t[i]) begin
      apply(t[i].s);
      tick();
      total++;
      if (o0 !== t[i].e0 || o1 !== t[i].e1) begin
        bad++;
        $display("FAIL basic step %0d: got %b/%b want %b/%b",
                 i, o0, o1, t[i].e0, t[i].e1);
      end
    end
  endtask

  task automatic test_lost();
    step_t t[12] = '{
      '{Q,     ARB, ARB},
      '{Q,     ARB, ARB},
      '{Q,     LST, LST},
      '{Q,     LST, LST},
      '{Q | S, ARB, ARB},
      '{Q | G, ARB, ARB},
      '{Q | G, WT,  WT },
      '{Q,     WT,  WT },
      '{Q | A, GNT, GNT},
      '{Q,     OWN, OWN},
      '{D,     IDL, IDL},
      '{8'h00, IDL, IDL}
    };
    foreach (t[i]) begin
      apply(t[i].s);
      tick();
      total++;
      if (o0 !== t[i].e0 || o1 !== t[i].e1) begin
        bad++;
        $display("FAIL lost step %0d: got %b/%b want %b/%b",
                 i, o0, o1, t[i].e0, t[i].e1);
      end
    end
  endtask

  task automatic test_fair();
    step_t t[11] = '{
      '{Q | B | G, ARB, ARB},
      '{Q | B | G, ARB, ARB},
      '{Q | B | G, WT,  WT },
      '{Q | B | G, GNT, GNT},
      '{Q | B | D, IDL, IDL},
      '{Q | B,     IDL, ARB},
      '{Q | B | G, IDL, ARB},
      '{Q | G,     IDL, WT },
      '{Q | B | G, ARB, GNT},
      '{D | B,     IDL, IDL},
      '{8'h00,     IDL, IDL}
    };
    foreach (t[i]) begin
      apply(t[i].s);
      tick();
      total++;
      if (o0 !== t[i].e0 || o1 !== t[i].e1) begin
        bad++;
        $display("FAIL fair step %0d: got %b/%b want %b/%b",
                 i, o0, o1, t[i].e0, t[i].e1);
      end
    end
  endtask

  task automatic test_lock();
    step_t t[8] = '{
      '{Q | G,     ARB, ARB},
      '{Q | G,     ARB, ARB},
      '{Q | G,     WT,  WT },
      '{Q | G,     GNT, GNT},
      '{Q | L | D, OWN, OWN},
      '{Q,         OWN, OWN},
      '{Q | D,     IDL, IDL},
      '{8'h00,     IDL, IDL}
    };
    foreach (t[i]) begin
      apply(t[i].s);
      tick();
      total++;
      if (o0 !== t[i].e0 || o1 !== t[i].e1) begin
        bad++;
        $display("FAIL lock step %0d: got %b/%b want %b/%b",
                 i, o0, o1, t[i].e0, t[i].e1);
      end
    end
  endtask

  task automatic test_abort();
    step_t t[6] = '{
      '{Q,     ARB, ARB},
      '{8'h00, IDL, IDL},
      '{Q,     ARB, ARB},
      '{Q,     ARB, ARB},
      '{Q,     LST, LST},
      '{8'h00, IDL, IDL}
    };
    foreach (t[i]) begin
      apply(t[i].s);
      tick();
      total++;
      if (o0 !== t[i].e0 || o1 !== t[i].e1) begin
        bad++;
        $display("FAIL abort step %0d: got %b/%b want %b/%b",
                 i, o0, o1, t[i].e0, t[i].e1);
      end
    end
  endtask

  task automatic test_reset_mid();
    step_t t[12] = '{
      '{Q | S | G, ARB, ARB},
      '{Q | G,     ARB, ARB},
      '{Q | G,     WT,  WT },
      '{R | Q | G, IDL, IDL},
      '{Q | G,     ARB, ARB},
      '{Q | G,     ARB, ARB},
      '{Q | G,     WT,  WT },
      '{Q | G,     GNT, GNT},
      '{Q,         OWN, OWN},
      '{R | Q | D, IDL, IDL},
      '{8'h00,     IDL, IDL},
      '{8'h00,     IDL, IDL}
    };
    foreach (t[i]) begin
      apply(t[i].s);
      tick();
      total++;
      if (o0 !== t[i].e0 || o1 !== t[i].e1) begin
        bad++;
        $display("FAIL rstmid step %0d: got %b/%b want %b/%b",
                 i, o0, o1, t[i].e0, t[i].e1);
      end
    end
  endtask

  task automatic test_random();
    logic [7:0] s;
    logic [3:0] x0;
    logic [3:0] x1;
    for (int i = 0; i < 800; i++) begin
      s = 8'h00;
      s[7] = ($urandom_range(0, 59) == 0);
      s[6] = ($urandom_range(0, 3) != 0);
      s[5] = ($urandom_range(0, 1) == 0);
      s[4] = ($urandom_range(0, 4) == 0);
      s[3] = ($urandom_range(0, 6) == 0);
      s[2] = ($urandom_range(0, 4) == 0);
      s[1] = ($urandom_range(0, 1) == 0);
      s[0] = ($urandom_range(0, 1) == 0);
      apply(s);
      tick();
      x0 = mexp(0);
      x1 = mexp(1);
      total++;
      if (o0 !== x0 || o1 !== x1) begin
        bad++;
        $display("FAIL random cyc %0d in=%b: got %b/%b want %b/%b",
                 i, s, o0, o1, x0, x1);
      end
      total++;
      if ((((o0[1] | o0[0]) & o0[2]) !== 1'b0) ||
          (((o1[1] | o1[0]) & o1[2]) !== 1'b0)) begin
        bad++;
        $display("FAIL owner_vs_arbena cyc %0d: got %b/%b want no overlap",
                 i, o0, o1);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_lost();
    test_fair();
    test_lock();
    test_abort();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
